// File: rtl/xl_mem_initiator_if.sv
// -----------------------------------------------------------------------------
// xl_mem_initiator_if
// Bundles the command, write-data, read-data, status, memory-side and counter
// signals of xl_mem_initiator.
//   master : the initiator's view (drives cmd_ready, wr/rd data handshakes,
//            status, memory-side controls and byte counters)
//   slave  : the environment's view (command source, data source/sink, memory)
// Parameters: ADDR_W (address width), DATA_W (byte-lane width).
// -----------------------------------------------------------------------------
interface xl_mem_initiator_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  // write data
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  // read data
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  // status
  logic              done;
  logic              done_eof;
  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_addr_update;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_full;
  logic              mem_w_open;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_empty;
  logic              mem_eof;
  logic              mem_r_open;
  // byte counters
  logic [15:0]       wr_count;
  logic [15:0]       rd_count;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    input  mem_full, mem_rdata, mem_empty, mem_eof,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, done_eof,
    output mem_addr, mem_addr_update, mem_wren, mem_wdata, mem_w_open,
    output mem_rden, mem_r_open, wr_count, rd_count
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready,
    output mem_full, mem_rdata, mem_empty, mem_eof,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, done_eof,
    input  mem_addr, mem_addr_update, mem_wren, mem_wdata, mem_w_open,
    input  mem_rden, mem_r_open, wr_count, rd_count
  );
endinterface

// File: rtl/xl_mem_initiator.sv
// -----------------------------------------------------------------------------
// xl_mem_initiator
// Burst initiator between a command/stream side and a byte-wide memory port.
// A command (start address, length-1, direction) is accepted in IDLE, the
// address is published for one cycle (ADDR), then bytes are streamed from
// wr_data into memory (WRITE) or from memory into a 2-entry read buffer that
// feeds rd_data (READ/DRAIN). A one-cycle done pulse ends each burst;
// done_eof flags a read burst cut short by mem_eof.
// Ports:
//   bus_clk   - single clock
//   bus_rst_n - asynchronous active-low reset
//   bus_if    - xl_mem_initiator_if.master (command, data, status, memory,
//               byte counters)
// Optional feature: define XL_MEM_BYTE_COUNT_EN to build saturating byte
// counters on wr_count/rd_count; otherwise both read as constant 0.
// -----------------------------------------------------------------------------
module xl_mem_initiator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic               bus_clk,
  input  logic               bus_rst_n,
  xl_mem_initiator_if.master bus_if
);
  // One extra bit: a burst may be a full 2^ADDR_W bytes long.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  left_q, left_d;   // bytes still to write / to issue
  logic              write_q, write_d;
  logic              eof_q, eof_d;
  logic              inflight_q;       // rden issued last cycle, data arrives now
  logic [DATA_W-1:0] buf_q [2];
  logic              head_q;
  logic [1:0]        occ_q, occ_d;
  logic              cmd_ready_int;
  logic              wren, rden, push, pop, wr_slot;

  // cmd_ready is held low for as long as reset is asserted.
  assign cmd_ready_int = (state_q == IDLE) & bus_rst_n;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    write_d = write_q;
    eof_d   = eof_q;
    wren    = 1'b0;
    rden    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_if.cmd_valid && cmd_ready_int) begin
          write_d = bus_if.cmd_write;
          addr_d  = bus_if.cmd_addr;
          left_d  = {1'b0, bus_if.cmd_len} + CNT_W'(1);
          eof_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: state_d = write_q ? WRITE : READ;
      WRITE: begin
        wren = bus_if.wr_valid & ~bus_if.mem_full;
        if (wren) begin
          addr_d = addr_q + ADDR_W'(1);
          left_d = left_q - CNT_W'(1);
          if (left_q == CNT_W'(1)) state_d = DONE;
        end
      end
      READ: begin
        if (bus_if.mem_eof) begin
          eof_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          // Only issue when the buffer is guaranteed room for the returning byte.
          rden = ~bus_if.mem_empty && ((occ_q + {1'b0, inflight_q}) < 2'd2) &&
                 (left_q != '0);
          if (rden) begin
            addr_d = addr_q + ADDR_W'(1);
            left_d = left_q - CNT_W'(1);
          end
          if (left_d == '0) state_d = DRAIN;
        end
      end
      DRAIN: if (!inflight_q && (occ_q == 2'd0)) state_d = DONE;
      DONE: begin
        eof_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      write_q    <= 1'b0;
      eof_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      write_q    <= write_d;
      eof_q      <= eof_d;
      inflight_q <= rden;
    end
  end

  // Two-entry read buffer: the byte arriving this cycle goes to the slot after
  // the current occupants; a push always finds room because issue was gated.
  assign push    = inflight_q;
  assign pop     = (occ_q != 2'd0) & bus_if.rd_ready;
  assign wr_slot = head_q ^ occ_q[0];
  assign occ_d   = occ_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      head_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push) buf_q[wr_slot] <= bus_if.mem_rdata;
      head_q <= head_q ^ pop;
      occ_q  <= occ_d;
    end
  end

  assign bus_if.cmd_ready       = cmd_ready_int;
  assign bus_if.wr_ready        = wren;
  assign bus_if.rd_valid        = (occ_q != 2'd0);
  assign bus_if.rd_data         = buf_q[head_q];
  assign bus_if.done            = (state_q == DONE);
  assign bus_if.done_eof        = (state_q == DONE) & eof_q;
  assign bus_if.mem_addr        = addr_q;
  assign bus_if.mem_addr_update = (state_q == ADDR);
  assign bus_if.mem_wren        = wren;
  assign bus_if.mem_wdata       = (state_q == WRITE) ? bus_if.wr_data : '0;
  assign bus_if.mem_rden        = rden;
  assign bus_if.mem_w_open      = (state_q != IDLE) & write_q;
  assign bus_if.mem_r_open      = (state_q != IDLE) & ~write_q;

`ifdef XL_MEM_BYTE_COUNT_EN
  logic [15:0] wr_count_q, rd_count_q;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      if (wren && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
      if (rden && (rd_count_q != 16'hFFFF)) rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign bus_if.wr_count = wr_count_q;
  assign bus_if.rd_count = rd_count_q;
`else
  assign bus_if.wr_count = '0;
  assign bus_if.rd_count = '0;
`endif

endmodule

// File: tb/tb_xl_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_xl_mem_initiator
// Drives directed and randomized bursts into xl_mem_initiator through its
// interface, with a 1-cycle-latency memory model. Expected write addresses,
// memory contents, read byte streams and done_eof come from a reference memory
// image and the burst rules (address = start + i mod depth, eof truncation).
// -----------------------------------------------------------------------------
module tb_xl_mem_initiator;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic bus_clk   = 1'b0;
  logic bus_rst_n = 1'b0;

  xl_mem_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  xl_mem_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .bus_clk  (bus_clk),
    .bus_rst_n(bus_rst_n),
    .bus_if   (bus_if)
  );

  always #5 bus_clk = ~bus_clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: 1-cycle read latency, optional fill with addr value.
  logic [DW-1:0] tb_mem [DEPTH];
  logic          mem_init;

  always @(posedge bus_clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= DW'(i);
    end else if (bus_if.mem_wren) begin
      tb_mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    end
    if (bus_if.mem_rden) bus_if.mem_rdata <= tb_mem[bus_if.mem_addr];
  end

  // Reference image of memory, bytes offered on wr_data, bytes moved since reset.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wq[$];
  int            tot_wr = 0;
  int            tot_rd = 0;

  function automatic logic [63:0] out_vec();
    return 64'({bus_if.cmd_ready, bus_if.wr_ready, bus_if.rd_valid, bus_if.rd_data,
                bus_if.done, bus_if.done_eof, bus_if.mem_addr, bus_if.mem_addr_update,
                bus_if.mem_wren, bus_if.mem_wdata, bus_if.mem_w_open, bus_if.mem_rden,
                bus_if.mem_r_open, bus_if.wr_count, bus_if.rd_count});
  endfunction

  function automatic logic [63:0] exp_count(input int n);
`ifdef XL_MEM_BYTE_COUNT_EN
    return (n > 65535) ? 64'd65535 : 64'(n);
`else
    return (n < 0) ? 64'd1 : 64'd0;
`endif
  endfunction

  task automatic drive_inputs(input int cyc, input int stall, input int full_lo,
                              input int full_hi, input bit rnd, input bit eof);
    bus_if.wr_valid  = (wq.size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
    bus_if.wr_data   = (wq.size() > 0) ? wq[0] : DW'($urandom);
    bus_if.rd_ready  = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    bus_if.mem_full  = rnd ? ($urandom_range(0, 3) == 0) : ((cyc >= full_lo) && (cyc <= full_hi));
    bus_if.mem_empty = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    bus_if.mem_eof   = eof;
  endtask

  task automatic run_burst(input bit wr, input int addr, input int len, input int eof_lim,
                           input int stall, input int full_lo, input int full_hi, input bit rnd);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int wa_q[$];
    int ra_q[$];
    int nb, n_exp, au_cnt, au_addr, both, stall_rd, full_viol, open_err, rden_n;
    int data_err, addr_err, mem_err;
    bit fin, wr_pop, exp_eof, seen_eof;
    nb = len + 1;
    au_cnt = 0; au_addr = -1; both = 0; stall_rd = 0; full_viol = 0; open_err = 0;
    rden_n = 0; data_err = 0; addr_err = 0; mem_err = 0; fin = 0; seen_eof = 0;
    if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[(addr + i) % DEPTH] = wq[i];
      n_exp   = nb;
      exp_eof = 1'b0;
    end else begin
      n_exp   = (eof_lim < nb) ? eof_lim : nb;
      exp_eof = (eof_lim < nb);
      for (int i = 0; i < n_exp; i++) exp_q.push_back(ref_mem[(addr + i) % DEPTH]);
    end

    @(posedge bus_clk); #1;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_addr  = AW'(addr);
    bus_if.cmd_len   = AW'(len);
    drive_inputs(0, stall, full_lo, full_hi, rnd, 1'b0);

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge bus_clk);
      if (cyc == 0) check("cmd_ready_accept", 64'(bus_if.cmd_ready), 64'd1);
      if (bus_if.mem_addr_update) begin au_cnt++; au_addr = int'(bus_if.mem_addr); end
      if (bus_if.mem_wren) wa_q.push_back(int'(bus_if.mem_addr));
      if (bus_if.mem_rden) begin
        ra_q.push_back(int'(bus_if.mem_addr));
        rden_n++;
        if (cyc < stall) stall_rd++;
      end
      if (bus_if.mem_wren && bus_if.mem_rden) both++;
      if (bus_if.mem_full && bus_if.wr_ready) full_viol++;
      if (cyc >= 1 && (bus_if.mem_w_open !== wr || bus_if.mem_r_open !== !wr)) open_err++;
      if (bus_if.rd_valid && bus_if.rd_ready) got_q.push_back(bus_if.rd_data);
      if (bus_if.done) begin fin = 1; seen_eof = bus_if.done_eof; end
      wr_pop = bus_if.wr_valid && bus_if.wr_ready;
      @(posedge bus_clk); #1;
      bus_if.cmd_valid = 1'b0;
      if (wr_pop) void'(wq.pop_front());
      drive_inputs(cyc + 1, stall, full_lo, full_hi, rnd, rden_n >= eof_lim);
    end
    if (!fin) check("done_timeout", 64'd0, 64'd1);
    bus_if.rd_ready = 1'b0;
    bus_if.mem_eof  = 1'b0;
    wq.delete();

    check("done_eof", 64'(seen_eof), 64'(exp_eof));
    check("addr_update_cnt", 64'(au_cnt), 64'd1);
    check("addr_update_addr", 64'(au_addr), 64'(addr));
    check("wren_rden_overlap", 64'(both), 64'd0);
    check("open_flags", 64'(open_err), 64'd0);
    if (wr) begin
      check("wren_cnt", 64'(wa_q.size()), 64'(nb));
      for (int i = 0; i < wa_q.size(); i++)
        if (wa_q[i] != (addr + i) % DEPTH) addr_err++;
      check("wren_addrs", 64'(addr_err), 64'd0);
      check("full_blocks_ready", 64'(full_viol), 64'd0);
      for (int a = 0; a < DEPTH; a++) if (tb_mem[a] !== ref_mem[a]) mem_err++;
      check("mem_contents", 64'(mem_err), 64'd0);
    end else begin
      check("rden_cnt", 64'(ra_q.size()), 64'(n_exp));
      for (int i = 0; i < ra_q.size(); i++)
        if (ra_q[i] != (addr + i) % DEPTH) addr_err++;
      check("rden_addrs", 64'(addr_err), 64'd0);
      check("rd_bytes", 64'(got_q.size()), 64'(n_exp));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) data_err++;
      check("rd_data", 64'(data_err), 64'd0);
      if (stall > 0 && !rnd) check("stall_rden", 64'(stall_rd), 64'd2);
    end
    tot_wr += wa_q.size();
    tot_rd += ra_q.size();

    @(negedge bus_clk);
    check("done_pulse_end", 64'(bus_if.done), 64'd0);
    check("idle_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    check("wr_count", 64'(bus_if.wr_count), exp_count(tot_wr));
    check("rd_count", 64'(bus_if.rd_count), exp_count(tot_rd));
    $display("burst %s addr=%0d len=%0d wren=%0d rden=%0d rd=%0d eof=%0d",
             wr ? "WR" : "RD", addr, len, wa_q.size(), ra_q.size(), got_q.size(), seen_eof);
  endtask

  initial begin
    int wr, addr, len, eof_lim;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = '0;   bus_if.cmd_len   = '0;
    bus_if.wr_valid  = 1'b0; bus_if.wr_data   = '0;
    bus_if.rd_ready  = 1'b0; bus_if.mem_full  = 1'b0;
    bus_if.mem_empty = 1'b0; bus_if.mem_eof   = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);

    #12;
    check("reset_outputs", out_vec(), 64'd0);
    @(posedge bus_clk); #3;
    bus_rst_n = 1'b1;
    mem_init  = 1'b0;
    @(negedge bus_clk);
    check("cmd_ready_after_reset", 64'(bus_if.cmd_ready), 64'd1);

    // 4-byte write at 3
    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_burst(1, 3, 3, 1000, 0, 1000, -1, 0);
    // same write with memory full during WRITE cycles 2-4
    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_burst(1, 3, 3, 1000, 0, 3, 5, 0);
    // read across the wrap
    run_burst(0, 30, 3, 1000, 0, 1000, -1, 0);
    // 8-byte read with sink stalled for 10 cycles
    run_burst(0, 8, 7, 1000, 10, 1000, -1, 0);
    // 8-byte read with eof after 3 issues
    run_burst(0, 12, 7, 3, 0, 1000, -1, 0);
    // full-depth write from a non-zero address
    for (int i = 0; i < DEPTH; i++) wq.push_back(DW'($urandom));
    run_burst(1, 5, DEPTH - 1, 1000, 0, 1000, -1, 0);

    // randomized bursts
    for (int n = 0; n < 20; n++) begin
      wr      = int'($urandom_range(0, 1));
      addr    = int'($urandom_range(0, DEPTH - 1));
      len     = int'($urandom_range(0, DEPTH - 1));
      eof_lim = 1000;
      if (wr == 1) begin
        for (int i = 0; i <= len; i++) wq.push_back(DW'($urandom));
      end else if ($urandom_range(0, 2) == 0) begin
        eof_lim = int'($urandom_range(1, len + 1));
      end
      run_burst(wr[0], addr, len, eof_lim, 0, 1000, -1, 1);
    end

    // reset in the middle of a read burst
    @(posedge bus_clk); #1;
    bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = AW'(10); bus_if.cmd_len = AW'(7);
    bus_if.rd_ready  = 1'b0;
    @(posedge bus_clk); #1;
    bus_if.cmd_valid = 1'b0;
    repeat (4) @(posedge bus_clk);
    #1;
    bus_rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", out_vec(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge bus_clk);
      check("mid_reset_no_done", 64'(bus_if.done), 64'd0);
    end
    @(posedge bus_clk); #2;
    bus_rst_n = 1'b1;
    tot_wr = 0;
    tot_rd = 0;
    @(negedge bus_clk);
    check("mid_reset_rd_count", 64'(bus_if.rd_count), 64'd0);
    check("mid_reset_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    run_burst(0, 10, 7, 1000, 0, 1000, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
